// File: rtl/arithmetic_unit_reg_if.sv
// Operand/result bundle for the registered arithmetic unit.
// Latency: none (wires only); the unit behind it adds one register stage.
// Backpressure: none; the master presents one operation every cycle.
interface arithmetic_unit_reg_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       sel;
  logic [WIDTH-1:0] Q;
  logic             overflow;

  // Control side: drives operands and op select, observes the result.
  modport master (
    output A, B, sel,
    input  Q, overflow
  );

  // Arithmetic unit side.
  modport slave (
    input  A, B, sel,
    output Q, overflow
  );
endinterface

// File: rtl/arithmetic_unit_reg.sv
// Signed add/sub/mul/negate with wrap-around result and signed-overflow flag.
// Latency: 1 cycle; operands sampled at edge N show on Q/overflow after edge N.
// Backpressure: none; a new operation is accepted every cycle.
module arithmetic_unit_reg #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  arithmetic_unit_reg_if.slave bus
);

  localparam int FW = 2 * WIDTH;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_NEG = 2'b11
  } op_t;

  logic [FW-1:0]    a_ext;
  logic [FW-1:0]    b_ext;
  logic [FW-1:0]    r_full;
  logic [WIDTH:0]   r_top;
  logic             ovf_next;

  // Sign-extend both operands so every op is evaluated at full precision.
  // Working modulo 2^FW on sign-extended values gives the exact signed result,
  // because no op on WIDTH-bit operands can exceed FW signed bits.
  assign a_ext = {{WIDTH{bus.A[WIDTH-1]}}, bus.A};
  assign b_ext = {{WIDTH{bus.B[WIDTH-1]}}, bus.B};

  // Full-precision result selected by the op code; B is unused for negate.
  always_comb begin
    r_full = '0;
    case (op_t'(bus.sel))
      OP_ADD:  r_full = a_ext + b_ext;
      OP_SUB:  r_full = a_ext - b_ext;
      OP_MUL:  r_full = a_ext * b_ext;
      OP_NEG:  r_full = '0 - a_ext;
      default: r_full = '0;
    endcase
  end

  // The result fits WIDTH signed bits exactly when the top WIDTH+1 bits are
  // all copies of the sign; anything else means the wrapped Q is wrong.
  assign r_top    = r_full[FW-1:WIDTH-1];
  assign ovf_next = ~((&r_top) | ~(|r_top));

  // Output registers; reset clears them immediately and discards any capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.Q        <= '0;
      bus.overflow <= 1'b0;
    end else begin
      bus.Q        <= r_full[WIDTH-1:0];
      bus.overflow <= ovf_next;
    end
  end

endmodule

// File: tb/tb_arithmetic_unit_reg.sv
// Directed and exhaustive check of the registered arithmetic unit.
// Latency: expects results one rising edge after operands are applied.
// Backpressure: none; one vector is applied per cycle.
module tb_arithmetic_unit_reg;

  localparam int WIDTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  arithmetic_unit_reg_if #(.WIDTH(WIDTH)) bus ();

  arithmetic_unit_reg #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply(input int a, input int b, input int s);
    bus.A   = 4'(a);
    bus.B   = 4'(b);
    bus.sel = 2'(s);
  endtask

  // Apply one operation, wait one edge, check wrapped result and flag.
  task automatic run_op(input string tag, input int a, input int b, input int s,
                        input int exp_q, input int exp_ovf);
    apply(a, b, s);
    @(posedge clk);
    #1;
    check({tag, "_q"},   int'(bus.Q),        exp_q & 'hF);
    check({tag, "_ovf"}, int'(bus.overflow), exp_ovf);
  endtask

  // Independent integer reference: exact result, then wrap and range test.
  task automatic model(input int a, input int b, input int s,
                       output int exp_q, output int exp_ovf);
    int r;
    case (s)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a * b;
      default: r = -a;
    endcase
    exp_q   = r & 'hF;
    exp_ovf = (r < -8 || r > 7) ? 1 : 0;
  endtask

  initial begin
    int eq;
    int eo;

    // Reset held from time zero with live operands on the bus.
    apply(5, 2, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_q",   int'(bus.Q),        0);
    check("rst_hold_ovf", int'(bus.overflow), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rel_q",   int'(bus.Q),        7);
    check("rst_rel_ovf", int'(bus.overflow), 0);

    // Add.
    run_op("add_3_4",   3,  4, 0,  7, 0);
    run_op("add_7_1",   7,  1, 0, -8, 1);
    run_op("add_m8_m1", -8, -1, 0, 7, 1);
    // Subtract.
    run_op("sub_m8_1",  -8,  1, 1,  7, 1);
    run_op("sub_2_5",    2,  5, 1, -3, 0);
    run_op("sub_0_m8",   0, -8, 1, -8, 1);
    // Multiply.
    run_op("mul_m2_3",  -2,  3, 2, -6, 0);
    run_op("mul_m3_3",  -3,  3, 2,  7, 1);
    run_op("mul_m8_m8", -8, -8, 2,  0, 1);
    // Negate, B deliberately non-zero to show it is ignored.
    run_op("neg_5",      5,  6, 3, -5, 0);
    run_op("neg_m8",    -8,  3, 3, -8, 1);

    // Mid-burst asynchronous reset: Q holds -8/ovf=1 before it lands.
    apply(3, 1, 0);
    #3;
    reset = 1'b1;
    #1;
    check("rst_async_q",   int'(bus.Q),        0);
    check("rst_async_ovf", int'(bus.overflow), 0);
    @(posedge clk);
    #1;
    check("rst_mid_q",   int'(bus.Q),        0);
    check("rst_mid_ovf", int'(bus.overflow), 0);
    reset = 1'b0;
    run_op("post_rst_add", 3, 1, 0, 4, 0);

    // Exhaustive sweep, one vector per cycle.
    for (int s = 0; s < 4; s++) begin
      for (int a = -8; a < 8; a++) begin
        for (int b = -8; b < 8; b++) begin
          model(a, b, s, eq, eo);
          run_op($sformatf("sweep_s%0d_a%0d_b%0d", s, a, b), a, b, s, eq, eo);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
